// File: rtl/instruction_register_pkg.sv
// Shared processor definitions: default instruction geometry and opcode encoding.
package instruction_register_pkg;

    localparam int unsigned DefaultDataWidth   = 16;
    localparam int unsigned DefaultOpcodeWidth = 4;

    typedef enum logic [DefaultOpcodeWidth-1:0] {
        OpNop   = 4'h0,
        OpLoad  = 4'h1,
        OpStore = 4'h2,
        OpAdd   = 4'h3,
        OpSub   = 4'h4,
        OpAnd   = 4'h5,
        OpOr    = 4'h6,
        OpXor   = 4'h7,
        OpShl   = 4'h8,
        OpShr   = 4'h9,
        OpJmp   = 4'hA,
        OpJz    = 4'hB,
        OpJnz   = 4'hC,
        OpCall  = 4'hD,
        OpRet   = 4'hE,
        OpHalt  = 4'hF
    } opcode_e;

endpackage

// File: rtl/instruction_register.sv
// Instruction register: captures a word on write_en and splits it into opcode/operand fields.
module instruction_register
    import instruction_register_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned OPCODE_WIDTH = DefaultOpcodeWidth
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           write_en,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [OPCODE_WIDTH-1:0]        opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                           loaded
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  loaded_d, loaded_q;

    // An unknown write_en falls through to hold rather than loading.
    always_comb begin
        data_d   = data_q;
        loaded_d = loaded_q;
        if (write_en) begin
            data_d   = data_in;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            loaded_q <= loaded_d;
        end
    end

    assign data_out = data_q;
    assign opcode   = data_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand  = data_q[DATA_WIDTH-OPCODE_WIDTH-1:0];
    assign loaded   = loaded_q;

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register.
module tb_instruction_register;

    logic        clock;
    logic        reset_n;
    logic        write_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        loaded;

    int checks;
    int failures;

    instruction_register dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .opcode   (opcode),
        .operand  (operand),
        .loaded   (loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // An unknown load enable outside reset is a stimulus error.
    always @(posedge clock) begin
        if (reset_n === 1'b1 && $isunknown(write_en)) begin
            failures++;
            $display("FAIL write_en_unknown: write_en=%b at posedge, required 0 or 1", write_en);
        end
    end

    task automatic check_out(input string name, input logic [15:0] exp_data,
                             input logic exp_loaded);
        checks++;
        if (data_out !== exp_data) begin
            failures++;
            $display("FAIL %s data_out: got %h, required %h", name, data_out, exp_data);
        end
        checks++;
        if (loaded !== exp_loaded) begin
            failures++;
            $display("FAIL %s loaded: got %b, required %b", name, loaded, exp_loaded);
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        @(negedge clock);
        write_en = 1'b1;
        data_in  = w;
        @(posedge clock);
        #1;
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        write_en = 1'b0;
        data_in  = 16'h0000;
        #1;
        check_out("reset_async", 16'h0000, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check_out("reset_hold", 16'h0000, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_out("reset_idle", 16'h0000, 1'b0);
    endtask

    task automatic test_load();
        load_word(16'd1);
        check_out("load", 16'd1, 1'b1);
    endtask

    task automatic test_hold();
        bit ok;
        ok = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        data_in  = 16'd2;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (data_out !== 16'd1) ok = 1'b0;
        end
        data_in = 16'd3;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (data_out !== 16'd1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hold: data_out changed, now %h, required 0001 throughout", data_out);
        end
        check_out("hold_end", 16'd1, 1'b1);
    endtask

    task automatic test_reload();
        load_word(16'd4);
        check_out("reload", 16'd4, 1'b1);
    endtask

    task automatic test_field_split();
        load_word(16'hA123);
        check_out("split", 16'hA123, 1'b1);
        checks++;
        if (opcode !== 4'hA) begin
            failures++;
            $display("FAIL split opcode: got %h, required a", opcode);
        end
        checks++;
        if (operand !== 12'h123) begin
            failures++;
            $display("FAIL split operand: got %h, required 123", operand);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        words[2] = 16'h9ABC;
        @(negedge clock);
        write_en = 1'b1;
        data_in  = words[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (i < 2) data_in = words[i+1];
            else       write_en = 1'b0;
            check_out("back_to_back", words[i], 1'b1);
        end
        checks++;
        if (opcode !== 4'h9 || operand !== 12'hABC) begin
            failures++;
            $display("FAIL back_to_back fields: got %h/%h, required 9/abc", opcode, operand);
        end
    endtask

    task automatic test_reset_mid();
        load_word(16'hFFFF);
        check_out("pre_reset", 16'hFFFF, 1'b1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("reset_mid", 16'h0000, 1'b0);
        checks++;
        if (opcode !== 4'h0 || operand !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid fields: got %h/%h, required 0/000", opcode, operand);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clock);
        write_en = 1'b1;
        data_in  = 16'd5;
        repeat (2) begin
            @(posedge clock);
            #1;
            check_out("reset_priority", 16'h0000, 1'b0);
        end
        @(negedge clock);
        write_en = 1'b0;
    endtask

    task automatic test_reset_release();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_out("release_idle", 16'h0000, 1'b0);
        load_word(16'd5);
        check_out("release_load", 16'd5, 1'b1);
        checks++;
        if (opcode !== 4'h0 || operand !== 12'h005) begin
            failures++;
            $display("FAIL release fields: got %h/%h, required 0/005", opcode, operand);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load();
        test_hold();
        test_reload();
        test_field_split();
        test_back_to_back();
        test_reset_mid();
        test_reset_priority();
        test_reset_release();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
